iommu_reg_arbiter: RTL and testbench
====================================

IOMMU_REG_ARBITER -- requirements
Module: iommu_reg_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of register-interface requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: register address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: register data width; strobe width is DATA_WIDTH/8.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum downstream wait cycles, 1..65535.
REQ-005 SHALL have port clk_i  input  1  single rising-edge clock.
REQ-006 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port req_valid_i  input  N_REQ  per-requester request valid.
REQ-008 SHALL have port req_write_i  input  N_REQ  per-requester write (1) / read (0).
REQ-009 SHALL have port req_addr_i  input  N_REQ*ADDR_WIDTH  per-requester address, requester i in slice i.
REQ-010 SHALL have port req_wdata_i  input  N_REQ*DATA_WIDTH  per-requester write data.
REQ-011 SHALL have port req_wstrb_i  input  N_REQ*DATA_WIDTH/8  per-requester byte strobes.
REQ-012 SHALL have port req_ready_o  output  N_REQ  per-requester completion pulse.
REQ-013 SHALL have port rsp_rdata_o  output  DATA_WIDTH  shared read data, valid with req_ready_o.
REQ-014 SHALL have port rsp_error_o  output  1  shared error flag, valid with req_ready_o.
REQ-015 SHALL have ports reg_valid_o, reg_write_o (1), reg_addr_o (ADDR_WIDTH), reg_wdata_o (DATA_WIDTH), reg_wstrb_o (DATA_WIDTH/8): outputs toward the IOMMU register map.
REQ-016 SHALL have ports reg_ready_i (1), reg_rdata_i (DATA_WIDTH), reg_error_i (1): inputs from the register map.
REQ-017 SHALL have ports gnt_idx_o  output  $clog2(N_REQ)  current/last grant; busy_o  output  1  high outside IDLE.

Function
REQ-018 SHALL implement FSM IDLE, BUSY, RESP; one transaction in flight.
REQ-019 IDLE: if any req_valid_i high, SHALL pick one round-robin, latch its write/addr/wdata/wstrb, set gnt_idx_o, go BUSY next cycle; else stay.
REQ-020 Round-robin SHALL search from (last_grant+1) mod N_REQ upward with wrap; last_grant updates only on grant.
REQ-021 BUSY: SHALL drive reg_valid_o=1 with latched fields held stable; on reg_ready_i=1 SHALL register reg_rdata_i/reg_error_i and go RESP.
REQ-022 RESP: SHALL assert req_ready_o[gnt] for exactly one cycle with registered rsp_rdata_o/rsp_error_o, then go IDLE.
REQ-023 Latency: request seen in IDLE at cycle t -> reg_valid_o at t+1; reg_ready_i at t+k -> req_ready_o at t+k+1; min 3 cycles end to end.
REQ-024 Requesters SHALL hold valid and fields until req_ready_o; changes after latch are ignored.
REQ-025 A requester deasserting valid in the RESP cycle SHALL not be re-granted; one still valid in IDLE is eligible again at its round-robin turn.
REQ-026 rsp_rdata_o SHALL be 0 for writes; req_ready_o bits other than gnt SHALL stay 0.
REQ-027 reg_valid_o SHALL be 0 in IDLE and RESP; no back-to-back downstream valid without an intervening low cycle.

Reset
REQ-028 rst_i high at a clock edge SHALL force IDLE, last_grant=N_REQ-1 (requester 0 first), gnt_idx_o=0, all outputs 0, timeout counter 0.
REQ-029 Reset mid-transaction SHALL drop reg_valid_o next cycle and discard the transaction without req_ready_o.

Configuration
REQ-030 Macro IOMMU_REG_ARB_TIMEOUT_EN defined: BUSY SHALL count cycles with reg_ready_i low; at count==TIMEOUT SHALL deassert reg_valid_o, go RESP with rsp_error_o=1, rsp_rdata_o=0; counter clears on entering BUSY.
REQ-031 Macro undefined: no counter; BUSY SHALL wait indefinitely for reg_ready_i.

Verification
REQ-032 Single read: req0 addr 0x10, map ready after 2 cycles with rdata 0x0000_0000_DEAD_BEEF -> req_ready_o=01 at cycle 4, rsp_rdata_o=0x...DEADBEEF, error 0.
REQ-033 Contention: req0 and req1 both valid continuously from reset -> grants 0,1,0,1; no requester granted twice in a row.
REQ-034 Write with error: req1 write addr 0x20 wstrb 0x0F, map returns reg_error_i=1 -> req_ready_o=10, rsp_error_o=1, rsp_rdata_o=0.
REQ-035 Timeout (macro on, TIMEOUT=4): reg_ready_i never asserted -> reg_valid_o high exactly 4 cycles, then req_ready_o pulse with error 1; macro off -> reg_valid_o stays high.
REQ-036 Reset in BUSY: rst_i pulse while reg_valid_o=1 -> next cycle reg_valid_o=0, busy_o=0, no req_ready_o; next grant goes to requester 0.

Source files
------------

// File: rtl/iommu_reg_arbiter.sv
// Round-robin arbiter funnelling N_REQ register requesters onto one IOMMU register port.
// Optional downstream timeout is enabled by defining IOMMU_REG_ARB_TIMEOUT_EN.
module iommu_reg_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_REQ-1:0]                 req_valid_i,
  input  logic [N_REQ-1:0]                 req_write_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_wdata_i,
  input  logic [N_REQ*(DATA_WIDTH/8)-1:0]  req_wstrb_i,
  output logic [N_REQ-1:0]                 req_ready_o,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                             rsp_error_o,
  output logic                             reg_valid_o,
  output logic                             reg_write_o,
  output logic [ADDR_WIDTH-1:0]            reg_addr_o,
  output logic [DATA_WIDTH-1:0]            reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          reg_wstrb_o,
  input  logic                             reg_ready_i,
  input  logic [DATA_WIDTH-1:0]            reg_rdata_i,
  input  logic                             reg_error_i,
  output logic [$clog2(N_REQ)-1:0]         gnt_idx_o,
  output logic                             busy_o
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : gen_chk_nreq
    $error("N_REQ out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : gen_chk_timeout
    $error("TIMEOUT out of range");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                 state_q;
  logic [IdxW-1:0]        last_q;
  logic [IdxW-1:0]        gnt_q;
  logic [N_REQ-1:0]       req_ready_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic                   rsp_error_q;
  logic                   reg_valid_q;
  logic                   reg_write_q;
  logic [ADDR_WIDTH-1:0]  reg_addr_q;
  logic [DATA_WIDTH-1:0]  reg_wdata_q;
  logic [StrbW-1:0]       reg_wstrb_q;
`ifdef IOMMU_REG_ARB_TIMEOUT_EN
  logic [15:0]            cnt_q;
`endif

  logic                   any_valid;
  logic [IdxW-1:0]        pick;
  logic [IdxW-1:0]        idx;

  // Search starts one past the last grant so every requester gets its turn.
  always_comb begin
    any_valid = 1'b0;
    pick      = last_q;
    idx       = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IdxW'((32'(last_q) + k) % N_REQ);
      if (!any_valid && req_valid_i[idx]) begin
        any_valid = 1'b1;
        pick      = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      last_q      <= IdxW'(N_REQ - 1);
      gnt_q       <= '0;
      req_ready_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      reg_valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
`ifdef IOMMU_REG_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            gnt_q       <= pick;
            last_q      <= pick;
            reg_valid_q <= 1'b1;
            reg_write_q <= req_write_i[pick];
            reg_addr_q  <= req_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
            reg_wdata_q <= req_wdata_i[pick*DATA_WIDTH +: DATA_WIDTH];
            reg_wstrb_q <= req_wstrb_i[pick*StrbW +: StrbW];
`ifdef IOMMU_REG_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          if (reg_ready_i) begin
            rsp_rdata_q <= reg_write_q ? '0 : reg_rdata_i;
            rsp_error_q <= reg_error_i;
            reg_valid_q <= 1'b0;
            req_ready_q <= N_REQ'(1) << gnt_q;
            state_q     <= StResp;
          end
`ifdef IOMMU_REG_ARB_TIMEOUT_EN
          // Last waiting cycle: abandon the access and report an error.
          else if (cnt_q == 16'(TIMEOUT - 1)) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            reg_valid_q <= 1'b0;
            req_ready_q <= N_REQ'(1) << gnt_q;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        StResp: begin
          req_ready_q <= '0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign reg_valid_o = reg_valid_q;
  assign reg_write_o = reg_write_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_wstrb_o = reg_wstrb_q;
  assign gnt_idx_o   = gnt_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_iommu_reg_arbiter.sv
// Directed self-checking bench for iommu_reg_arbiter (N_REQ=2, TIMEOUT=4).
module tb_iommu_reg_arbiter;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_write;
  logic [63:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic [1:0]   req_ready;
  logic [63:0]  rsp_rdata;
  logic         rsp_error;
  logic         reg_valid;
  logic         reg_write;
  logic [31:0]  reg_addr;
  logic [63:0]  reg_wdata;
  logic [7:0]   reg_wstrb;
  logic         reg_ready;
  logic [63:0]  reg_rdata;
  logic         reg_error;
  logic         gnt_idx;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  iommu_reg_arbiter #(
    .N_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(4)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .req_ready_o(req_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error),
    .reg_valid_o(reg_valid),
    .reg_write_o(reg_write),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_wstrb_o(reg_wstrb),
    .reg_ready_i(reg_ready),
    .reg_rdata_i(reg_rdata),
    .reg_error_i(reg_error),
    .gnt_idx_o  (gnt_idx),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && reg_valid !== 1'b1; i++) tick();
    check(tag, 64'(reg_valid), 64'd1);
  endtask

  // One-cycle downstream completion; leaves the bench in the RESP cycle.
  task automatic respond(input string tag, input logic [63:0] rd, input logic err,
                         input logic [1:0] exp_rdy, input logic [63:0] exp_rd,
                         input logic exp_err);
    reg_ready = 1'b1;
    reg_rdata = rd;
    reg_error = err;
    tick();
    reg_ready = 1'b0;
    reg_error = 1'b0;
    check({tag, "_rdy"}, 64'(req_ready), 64'(exp_rdy));
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, 64'(rsp_error), 64'(exp_err));
    check({tag, "_vld_low"}, 64'(reg_valid), 64'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; reg_ready = 1'b0; reg_rdata = '0; reg_error = 1'b0;
    tick();
    do_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_vld", 64'(reg_valid), 64'd0);
    check("rst_rdy", 64'(req_ready), 64'd0);
    check("rst_gnt", 64'(gnt_idx), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);

    // Single read from requester 0, map ready two cycles after valid.
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h10;
    tick();
    check("rd_vld_t1", 64'(reg_valid), 64'd1);
    check("rd_addr", 64'(reg_addr), 64'h10);
    check("rd_write", 64'(reg_write), 64'd0);
    check("rd_gnt", 64'(gnt_idx), 64'd0);
    check("rd_busy", 64'(busy), 64'd1);
    req_addr[31:0] = 32'h99;
    tick();
    check("rd_vld_t2", 64'(reg_valid), 64'd1);
    check("rd_addr_held", 64'(reg_addr), 64'h10);
    tick();
    check("rd_rdy_t3", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    respond("rd", 64'h0000_0000_DEAD_BEEF, 1'b0, 2'b01, 64'h0000_0000_DEAD_BEEF, 1'b0);
    tick();
    check("rd_pulse_end", 64'(req_ready), 64'd0);
    check("rd_idle", 64'(busy), 64'd0);
    tick();
    check("rd_no_regrant", 64'(reg_valid), 64'd0);

    // Contention from reset: strict alternation 0,1,0,1.
    req_addr = {32'h204, 32'h104};
    do_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_valid("ct_wait");
      check("ct_gnt", 64'(gnt_idx), 64'(i % 2));
      check("ct_addr", 64'(reg_addr), (i % 2) ? 64'h204 : 64'h104);
      respond("ct", 64'(i + 1), 1'b0, (i % 2) ? 2'b10 : 2'b01, 64'(i + 1), 1'b0);
    end

    // Write from requester 1 with a downstream error.
    req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h20;
    req_wdata[127:64] = 64'hCAFE_F00D_1234_5678; req_wstrb[15:8] = 8'h0F;
    wait_valid("wr_wait");
    check("wr_gnt", 64'(gnt_idx), 64'd1);
    check("wr_write", 64'(reg_write), 64'd1);
    check("wr_addr", 64'(reg_addr), 64'h20);
    check("wr_wdata", reg_wdata, 64'hCAFE_F00D_1234_5678);
    check("wr_wstrb", 64'(reg_wstrb), 64'h0F);
    req_valid = 2'b00;
    respond("wr", 64'h5555_AAAA_5555_AAAA, 1'b1, 2'b10, 64'd0, 1'b1);
    req_write = 2'b00;

    // Stalled downstream: timeout response, or indefinite wait without the feature.
    req_valid = 2'b01;
    wait_valid("to_wait");
    req_valid = 2'b00;
`ifdef IOMMU_REG_ARB_TIMEOUT_EN
    cnt = 0;
    while (reg_valid === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    check("to_vld_cycles", 64'(cnt), 64'd4);
    check("to_rdy", 64'(req_ready), 64'b01);
    check("to_err", 64'(rsp_error), 64'd1);
    check("to_rdata", rsp_rdata, 64'd0);
`else
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (reg_valid === 1'b1 && req_ready === 2'b00) cnt++;
    end
    check("nto_vld_cycles", 64'(cnt), 64'd20);
    respond("nto", 64'h77, 1'b0, 2'b01, 64'h77, 1'b0);
`endif
    tick();
    tick();

    // Reset while BUSY discards the transaction and restores requester-0 priority.
    req_valid = 2'b10;
    wait_valid("rb_wait");
    check("rb_gnt", 64'(gnt_idx), 64'd1);
    req_valid = 2'b11;
    do_reset();
    check("rb_vld", 64'(reg_valid), 64'd0);
    check("rb_busy", 64'(busy), 64'd0);
    check("rb_rdy", 64'(req_ready), 64'd0);
    check("rb_gnt_rst", 64'(gnt_idx), 64'd0);
    wait_valid("rb_wait2");
    check("rb_next_gnt", 64'(gnt_idx), 64'd0);
    req_valid = 2'b00;
    respond("rb", 64'h1, 1'b0, 2'b01, 64'h1, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
